// File: rtl/mpu_spi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mpu_spi_responder_if
//  Description : SPI link bundle between the IMU SPI master and the
//                MPU-6500 register responder (mode 0, active-low CS).
//                master modport : drives sclk/mosi/cs_n, receives miso
//                slave  modport : receives sclk/mosi/cs_n, drives miso
//  Revision    : 1.0 - initial release
// ============================================================================
interface mpu_spi_responder_if;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs_n;
   logic spi_miso;

   modport master (output spi_sclk, output spi_mosi, output spi_cs_n, input spi_miso);
   modport slave  (input spi_sclk, input spi_mosi, input spi_cs_n, output spi_miso);
endinterface
`default_nettype wire

// File: rtl/mpu_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mpu_spi_responder
//  Description : SPI slave model of the MPU-6500 register interface. Serves
//                register reads/writes from the SPI master; sensor inputs are
//                snapshotted at the start of each frame so bursts are coherent.
//  Ports       : clk, rst_n (async, active-low)
//                spi          - SPI link (slave modport)
//                accel_*/temp/gyro_* - 16-bit sensor values to serve
//                pwr_mgmt_1, sleeping - PWR_MGMT_1 register and its SLEEP bit
//                wr_strobe/wr_addr/wr_data - one pulse per written data byte
//                frame_done   - pulse when CS deasserts after an active frame
//  Revision    : 1.0 - initial release
// ============================================================================
module mpu_spi_responder #(
   parameter logic [7:0] WHO_AM_I_VAL  = 8'h70,
   parameter logic [7:0] PWR_RESET_VAL = 8'h40
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   mpu_spi_responder_if.slave      spi,
   input  wire logic [15:0]        accel_x,
   input  wire logic [15:0]        accel_y,
   input  wire logic [15:0]        accel_z,
   input  wire logic [15:0]        temp,
   input  wire logic [15:0]        gyro_x,
   input  wire logic [15:0]        gyro_y,
   input  wire logic [15:0]        gyro_z,
   output logic [7:0]              pwr_mgmt_1,
   output logic                    sleeping,
   output logic                    wr_strobe,
   output logic [6:0]              wr_addr,
   output logic [7:0]              wr_data,
   output logic                    frame_done
);

   localparam logic [6:0] C_ADDR_PWR  = 7'h6B;
   localparam logic [6:0] C_ADDR_WHO  = 7'h75;
   localparam logic [6:0] C_ADDR_SNAP = 7'h3B;
   localparam logic [6:0] C_ADDR_LAST = 7'h48;

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

   state_t      r_state;
   logic [1:0]  r_sclk_s, r_mosi_s, r_cs_s;
   logic        r_sclk_d;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_rx;
   logic [7:0]  r_tx;
   logic [6:0]  r_addr;
   logic        r_rw;
   logic        r_miso_en;
   logic [7:0]  r_snap [14];

   logic        w_sclk_rise, w_sclk_fall, w_cs_fall;
   logic [7:0]  w_byte;

   assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
   assign w_cs_fall   = ~r_cs_s[1];
   assign w_byte      = {r_rx, r_mosi_s[1]};

   // MISO is a gate of two flops, so it drops to 0 in the same clk the FSM
   // leaves DATA/read.
   assign spi.spi_miso = r_miso_en & r_tx[7];
   assign sleeping     = pwr_mgmt_1[6];

   function automatic logic [7:0] f_reg(input logic [6:0] a);
      logic [7:0] v;
      v = 8'h00;
      if (a >= C_ADDR_SNAP && a <= C_ADDR_LAST)
         v = r_snap[4'(a - C_ADDR_SNAP)];
      else if (a == C_ADDR_PWR)
         v = pwr_mgmt_1;
      else if (a == C_ADDR_WHO)
         v = WHO_AM_I_VAL;
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sclk_s   <= 2'b00;
         r_mosi_s   <= 2'b00;
         r_cs_s     <= 2'b11;
         r_sclk_d   <= 1'b0;
         r_bit_cnt  <= 3'd0;
         r_rx       <= 7'd0;
         r_tx       <= 8'd0;
         r_addr     <= 7'd0;
         r_rw       <= 1'b0;
         r_miso_en  <= 1'b0;
         pwr_mgmt_1 <= PWR_RESET_VAL;
         wr_strobe  <= 1'b0;
         wr_addr    <= 7'd0;
         wr_data    <= 8'd0;
         frame_done <= 1'b0;
         for (int i = 0; i < 14; i++) r_snap[i] <= 8'h00;
      end else begin
         r_sclk_s   <= {r_sclk_s[0], spi.spi_sclk};
         r_mosi_s   <= {r_mosi_s[0], spi.spi_mosi};
         r_cs_s     <= {r_cs_s[0], spi.spi_cs_n};
         r_sclk_d   <= r_sclk_s[1];
         wr_strobe  <= 1'b0;
         frame_done <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_cs_fall) begin
                  r_state   <= ADDR;
                  r_bit_cnt <= 3'd0;
                  r_snap[0]  <= accel_x[15:8]; r_snap[1]  <= accel_x[7:0];
                  r_snap[2]  <= accel_y[15:8]; r_snap[3]  <= accel_y[7:0];
                  r_snap[4]  <= accel_z[15:8]; r_snap[5]  <= accel_z[7:0];
                  r_snap[6]  <= temp[15:8];    r_snap[7]  <= temp[7:0];
                  r_snap[8]  <= gyro_x[15:8];  r_snap[9]  <= gyro_x[7:0];
                  r_snap[10] <= gyro_y[15:8];  r_snap[11] <= gyro_y[7:0];
                  r_snap[12] <= gyro_z[15:8];  r_snap[13] <= gyro_z[7:0];
               end
            end

            ADDR, DATA: begin
               // CS release has priority over any coincident sclk edge; a
               // partial byte is simply dropped.
               if (!w_cs_fall) begin
                  r_state    <= IDLE;
                  r_miso_en  <= 1'b0;
                  frame_done <= 1'b1;
               end else if (w_sclk_rise) begin
                  r_rx      <= w_byte[6:0];
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (r_state == ADDR) begin
                        r_state   <= DATA;
                        r_rw      <= w_byte[7];
                        r_addr    <= w_byte[6:0];
                        r_miso_en <= w_byte[7];
                        if (w_byte[7])
                           r_tx <= f_reg(w_byte[6:0]);
                     end else begin
                        r_addr <= r_addr + 7'd1;
                        if (r_rw) begin
                           r_tx <= f_reg(r_addr + 7'd1);
                        end else begin
                           wr_strobe <= 1'b1;
                           wr_addr   <= r_addr;
                           wr_data   <= w_byte;
                           if (r_addr == C_ADDR_PWR)
                              pwr_mgmt_1 <= w_byte[7] ? PWR_RESET_VAL : w_byte;
                        end
                     end
                  end
               end else if (w_sclk_fall && r_state == DATA && r_rw && r_bit_cnt != 3'd0) begin
                  // The fall right after a byte boundary must not shift, so
                  // the freshly loaded MSB is presented for the next rise.
                  r_tx <= {r_tx[6:0], 1'b0};
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mpu_spi_responder.md
Name: mpu_spi_responder

Overview:
SPI slave model of the MPU-6500 register interface, the responder end of the IMU SPI link. Serves register reads and writes from our SPI master, so the sensor driver and Kalman datapath can be exercised in simulation and on-FPGA loopback without a physical IMU. Sensor values come from fabric inputs and are snapshotted once per frame, so burst reads are coherent.

Parameters:
WHO_AM_I_VAL, 8'h70, value returned at register 0x75
PWR_RESET_VAL, 8'h40, reset and DEVICE_RESET value of PWR_MGMT_1 (SLEEP bit set)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; rst_n, asynchronous, active-low; clock clk
spi_sclk  input  1  SPI clock from master, mode 0
spi_mosi  input  1  serial data from master
spi_cs_n  input  1  chip select, active-low
spi_miso  output  1  serial data to master
accel_x, accel_y, accel_z  input  16 each  signed sensor values to serve
temp  input  16  signed temperature value to serve
gyro_x, gyro_y, gyro_z  input  16 each  signed sensor values to serve
pwr_mgmt_1  output  8  current PWR_MGMT_1 register
sleeping  output  1  equals pwr_mgmt_1[6]
wr_strobe  output  1  one-clk pulse per completed write data byte
wr_addr  output  7  address of the last write byte
wr_data  output  8  data of the last write byte
frame_done  output  1  one-clk pulse when CS deasserts after an active frame

Behaviour:
- Reset values: spi_miso=0, pwr_mgmt_1=PWR_RESET_VAL, sleeping=PWR_RESET_VAL[6], wr_strobe=0, wr_addr=0, wr_data=0, frame_done=0, state IDLE, snapshot registers 0.
- Input sync: sclk, mosi and cs_n each pass through 2 flops. Edges are detected on the synced sclk. Each sclk high and low phase lasts at least 3 clk. A sclk edge is recognised 2-3 clk after the pin toggles.
- Mode 0, MSB first: MOSI is sampled on sclk rise. MISO changes after sclk fall.
- States:
  - IDLE: cs_n high, spi_miso=0.
  - ADDR: command byte.
  - DATA: data bytes.
- IDLE->ADDR on synced cs_n fall. In the same clk, all 14 sensor bytes are latched into a snapshot and bit_cnt=0.
- ADDR: shift 8 rising edges in. Byte[7]=R/W (1=read), byte[6:0]=address. On the 8th rise: latch rw and addr, go to DATA, bit_cnt wraps to 0. If read, load tx_shift with reg[addr]. spi_miso = tx_shift[7] in DATA/read, else 0.
- DATA/read: on sclk fall, shift tx_shift left only if bit_cnt!=0. This keeps the freshly loaded MSB. On each 8th rise: addr <= addr+1 (7-bit, wraps 0x7F->0x00) and load tx_shift with reg[addr+1].
- DATA/write: on each 8th rise:
  - Pulse wr_strobe for 1 clk; wr_addr=addr, wr_data=byte.
  - If addr==0x6B: if byte[7] (DEVICE_RESET) is set, pwr_mgmt_1 <= PWR_RESET_VAL, else pwr_mgmt_1 <= byte.
  - Then addr increments.
- Register map:
  - 0x3B-0x40: accel x/y/z, hi byte then lo byte.
  - 0x41-0x42: temp hi, lo.
  - 0x43-0x48: gyro x/y/z, hi then lo. All values from the snapshot.
  - 0x6B: pwr_mgmt_1.
  - 0x75: WHO_AM_I_VAL.
  - All other addresses read 0x00.
  - Only 0x6B is writable. Writes elsewhere are ignored but still strobe.
- Synced cs_n rise from ADDR/DATA: go to IDLE, spi_miso=0, pulse frame_done. Any partial byte is discarded, with no write and no strobe.
- cs_n rise and an sclk edge in the same clk: cs_n wins and the edge is ignored.
- sclk edges while IDLE are ignored.
- rst_n assertion mid-frame: everything returns to reset values immediately. The next cs_n fall starts a clean frame.
- Read latency: the MISO MSB is valid at least 1 sclk half-period before the master samples it, given the 3-clk phase minimum.

Test Plan:
- After reset, frame {0x6B, 0x00} -> pwr_mgmt_1 goes 0x40->0x00, sleeping=0, one wr_strobe with wr_addr=0x6B and wr_data=0x00, then one frame_done.
- Frame {0xF5, 0x00} -> master receives 0x70 in byte 2. A read of 0x6B after reset returns 0x40.
- Inputs accel_x=0x1234, accel_y=0xABCD, accel_z=0x0102, temp=0x0F0E, gyro_x=0x8000, gyro_y=0x7FFF, gyro_z=0xFFFE; frame 0xBB plus 14 dummies -> master receives 12 34 AB CD 01 02 0F 0E 80 00 7F FF FF FE.
- Change accel_x from 0x1234 to 0x5555 after byte 3 of a burst -> this frame returns 12 34; the next frame returns 55 55.
- Wrap: frame 0xFF plus 2 dummies -> 00 00 (regs 0x7F, 0x00). Frame 0xF4 plus 2 dummies -> 00 70.
- Abort and reset:
  - Write {0x6B, 0x00} with CS raised after 4 data bits -> pwr_mgmt_1 unchanged, no wr_strobe, frame_done pulses.
  - Write {0x6B, 0x80} -> pwr_mgmt_1=0x40.
  - rst_n pulsed mid-burst -> outputs reset; the next read of 0xF5 returns 0x70.
